// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between an instruction read port (A) and
// a data read/write port (B). B has priority; a starvation counter forces A.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_read,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  output logic                    a_resp,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH/8-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_resp,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic                    pmem_resp,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  output logic                    grant_b
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               b_req;
  logic               take_a;
  logic               take_b;
  logic               done;

  assign b_req = b_read | b_write;

  // Next-state, grant decode and same-cycle completion pulses.
  always_comb begin
    state_nxt = state;
    take_a    = 1'b0;
    take_b    = 1'b0;
    done      = 1'b0;
    a_resp    = 1'b0;
    b_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (b_req && (!a_read || (starve_cnt < CNT_W'(STARVE_LIMIT)))) begin
          take_b    = 1'b1;
          state_nxt = SERVE_B;
        end else if (a_read) begin
          take_a    = 1'b1;
          state_nxt = SERVE_A;
        end
      end
      SERVE_A: begin
        if (pmem_resp) begin
          a_resp    = 1'b1;
          done      = 1'b1;
          state_nxt = RECOVER;
        end
      end
      SERVE_B: begin
        if (pmem_resp) begin
          b_resp    = 1'b1;
          done      = 1'b1;
          state_nxt = RECOVER;
        end
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Downstream request is latched at grant so requester changes cannot leak through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wmask   <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      grant_b      <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      if (take_a) begin
        pmem_read    <= 1'b1;
        pmem_write   <= 1'b0;
        pmem_wmask   <= {MASK_W{1'b1}};
        pmem_address <= a_address;
      end else if (take_b) begin
        // Read+write together resolves to a write.
        pmem_read    <= ~b_write;
        pmem_write   <= b_write;
        pmem_wmask   <= b_write ? b_wmask : {MASK_W{1'b1}};
        pmem_address <= b_address;
        pmem_wdata   <= b_wdata;
      end else if (done) begin
        pmem_read    <= 1'b0;
        pmem_write   <= 1'b0;
      end
      grant_b <= (state_nxt == SERVE_B);
      if (a_resp) a_rdata <= pmem_rdata;
      if (b_resp) b_rdata <= pmem_rdata;
    end
  end

  // Counts B grants taken while A is waiting; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (take_a) begin
      starve_cnt <= '0;
    end else if (take_b && a_read) begin
      if (starve_cnt != {CNT_W{1'b1}}) starve_cnt <= starve_cnt + CNT_W'(1);
    end else if ((state == IDLE) && !a_read) begin
      starve_cnt <= '0;
    end
  end

endmodule
